// File: rtl/chunk_shift_pkg.sv
// rtl/chunk_shift_pkg.sv - shared types for the chunk shift engine
// Purpose : fill mode, shift direction and FSM state encodings used by
//           chunk_shift_engine and chunk_shift_lane.
// Ports   : none (package)
package chunk_shift_pkg;

  typedef enum logic [1:0] {SERIAL, TOGGLE, ROTATE, HOLD} fill_mode_t;

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

endpackage

// File: rtl/chunk_shift_lane.sv
// rtl/chunk_shift_lane.sv - one WIDTH-bit chunk of the shift chain
// Purpose : holds one word of the chain; loads it or shifts it by one bit
//           per enabled edge, taking the incoming bit from its neighbour
//           (or the end fill) through carry_lo_in / carry_hi_in.
//           Optional macro CHUNK_SHIFT_PARITY_EN adds a registered parity bit.
// Ports   : clock, reset_n      - clock, synchronous active-low reset
//           shift_en, dir       - shift this edge, direction
//           carry_lo_in         - bit entering bit 0 on an UP shift
//           carry_hi_in         - bit entering bit WIDTH-1 on a DOWN shift
//           load_en, load_word  - parallel load (wins over shift)
//           word, lsb, msb      - current word and its end bits
//           parity              - XOR of word (CHUNK_SHIFT_PARITY_EN only)
module chunk_shift_lane
  import chunk_shift_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter logic [WIDTH-1:0] RESET_WORD = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             shift_en,
  input  dir_t             dir,
  input  logic             carry_lo_in,
  input  logic             carry_hi_in,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_word,
  output logic [WIDTH-1:0] word,
  output logic             lsb,
  output logic             msb
`ifdef CHUNK_SHIFT_PARITY_EN
  ,
  output logic             parity
`endif
);

  logic [WIDTH-1:0] word_next;

  always_comb begin
    word_next = word;
    if (load_en) begin
      word_next = load_word;
    end else if (shift_en) begin
      if (dir == DIR_UP) begin
        word_next = {word[WIDTH-2:0], carry_lo_in};
      end else begin
        word_next = {carry_hi_in, word[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      word <= RESET_WORD;
    end else begin
      word <= word_next;
    end
  end

`ifdef CHUNK_SHIFT_PARITY_EN
  // Computed from word_next so parity tracks data on the same edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      parity <= ^RESET_WORD;
    end else begin
      parity <= ^word_next;
    end
  end
`endif

  assign lsb = word[0];
  assign msb = word[WIDTH-1];

endmodule

// File: rtl/chunk_shift_engine.sv
// rtl/chunk_shift_engine.sv - multi-chunk burst shift engine
// Purpose : CHUNKS words of WIDTH bits treated as one chain (data[0][0] is the
//           chain LSB). Runs bursts of `length` shifts in a latched direction
//           and fill mode; parallel load aborts any burst.
//           Optional macro CHUNK_SHIFT_PARITY_EN adds per-chunk parity output.
// Ports   : clock, reset_n          - clock, synchronous active-low reset
//           load, load_data         - parallel load image (highest priority)
//           start, length, mode, dir- burst request, sampled in IDLE
//           serial_in               - fill bit for SERIAL mode
//           busy, done              - burst in progress / one-cycle completion
//           serial_out              - bit shifted off the chain end last shift
//           data                    - chain contents
//           parity                  - per-chunk XOR (CHUNK_SHIFT_PARITY_EN only)
module chunk_shift_engine
  import chunk_shift_pkg::*;
#(
  parameter int          WIDTH  = 11,
  parameter int          CHUNKS = 5,
  parameter int unsigned INIT   = 0,
  parameter int          CNT_W  = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data [CHUNKS],
  input  logic             start,
  input  logic [CNT_W-1:0] length,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             serial_in,
  output logic             busy,
  output logic             done,
  output logic             serial_out,
  output logic [WIDTH-1:0] data [CHUNKS]
`ifdef CHUNK_SHIFT_PARITY_EN
  ,
  output logic             parity [CHUNKS]
`endif
);

  localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT);

  state_t           state;
  fill_mode_t       mode_q;
  dir_t             dir_q;
  logic [CNT_W-1:0] remaining;

  logic lane_lsb [CHUNKS];
  logic lane_msb [CHUNKS];
  logic chain_lsb, chain_msb;
  logic fill_lo, fill_hi;
  logic shift_en;

  assign chain_lsb = lane_lsb[0];
  assign chain_msb = lane_msb[CHUNKS-1];

  // HOLD bursts still run the counter but never move data.
  assign shift_en = (state == RUN) && (mode_q != HOLD);

  // fill_lo enters the chain LSB on UP shifts, fill_hi the MSB on DOWN shifts.
  always_comb begin
    fill_lo = serial_in;
    fill_hi = serial_in;
    case (mode_q)
      TOGGLE: begin
        fill_lo = ~chain_lsb;
        fill_hi = ~chain_msb;
      end
      ROTATE: begin
        fill_lo = chain_msb;
        fill_hi = chain_lsb;
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < CHUNKS; i++) begin : g_lane
    logic c_lo, c_hi;

    if (i == 0) begin : g_lo_end
      assign c_lo = fill_lo;
    end else begin : g_lo_link
      assign c_lo = lane_msb[i-1];
    end

    if (i == CHUNKS - 1) begin : g_hi_end
      assign c_hi = fill_hi;
    end else begin : g_hi_link
      assign c_hi = lane_lsb[i+1];
    end

    chunk_shift_lane #(
      .WIDTH      (WIDTH),
      .RESET_WORD ((i == 0) ? INIT_W : {WIDTH{1'b0}})
    ) u_lane (
      .clock       (clock),
      .reset_n     (reset_n),
      .shift_en    (shift_en),
      .dir         (dir_q),
      .carry_lo_in (c_lo),
      .carry_hi_in (c_hi),
      .load_en     (load),
      .load_word   (load_data[i]),
      .word        (data[i]),
      .lsb         (lane_lsb[i]),
      .msb         (lane_msb[i])
`ifdef CHUNK_SHIFT_PARITY_EN
      ,
      .parity      (parity[i])
`endif
    );
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      mode_q     <= SERIAL;
      dir_q      <= DIR_UP;
      remaining  <= '0;
      serial_out <= 1'b0;
    end else if (load) begin
      // Load aborts any burst without a done pulse.
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_q    <= fill_mode_t'(mode);
            dir_q     <= dir_t'(dir);
            remaining <= length;
            state     <= (length == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          remaining <= remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            state <= DONE;
          end
          if (mode_q != HOLD) begin
            serial_out <= (dir_q == DIR_UP) ? chain_msb : chain_lsb;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN) || (state == DONE);
  assign done = (state == DONE);

endmodule
